// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight: IDLE (accept) -> EXEC (capture result) -> RESP (hold until taken).
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [WIDTH-1:0]  resp0_result,
    output logic              resp0_zero,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [WIDTH-1:0]  resp1_result,
    output logic              resp1_zero,

    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [WIDTH-1:0]  a;
        logic [WIDTH-1:0]  b;
        logic [CTRL_W-1:0] ctrl;
    } op_t;

    state_t           state, state_nxt;
    op_t              op_q, op_sel;
    logic             owner_q, last_grant_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    logic any_req, gnt_sel, accept, owner_ready;

    assign any_req = req0_valid | req1_valid;

    // gnt_sel=1 picks port 1; on a tie the port that did not win last time goes
    always_comb begin
        if (req0_valid && req1_valid)
            gnt_sel = ~last_grant_q;
        else
            gnt_sel = req1_valid;
    end

    assign op_sel      = gnt_sel ? op_t'{req1_a, req1_b, req1_ctrl}
                                 : op_t'{req0_a, req0_b, req0_ctrl};
    assign accept      = (state == IDLE) && any_req;
    assign owner_ready = owner_q ? resp1_ready : resp0_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req)     state_nxt = EXEC;
            EXEC:                     state_nxt = RESP;
            RESP:    if (owner_ready) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Outputs; ready is masked during reset so no handshake is ever advertised then
    always_comb begin
        req0_ready  = rst_n && accept && !gnt_sel;
        req1_ready  = rst_n && accept &&  gnt_sel;
        resp0_valid = rst_n && (state == RESP) && !owner_q;
        resp1_valid = rst_n && (state == RESP) &&  owner_q;
    end

    // Operand, owner, arbitration history and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q         <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            result_q     <= '0;
            zero_q       <= 1'b0;
        end else begin
            if (accept) begin
                op_q         <= op_sel;
                owner_q      <= gnt_sel;
                last_grant_q <= gnt_sel;
            end
            if (state == EXEC) begin
                result_q <= alu_result;
                zero_q   <= alu_zero;
            end
        end
    end

    assign alu_a    = op_q.a;
    assign alu_b    = op_q.b;
    assign alu_ctrl = op_q.ctrl;

    assign resp0_result = result_q;
    assign resp0_zero   = zero_q;
    assign resp1_result = result_q;
    assign resp1_zero   = zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter; a small RV32I ALU model closes the loop.
module tb_alu_share_arbiter;

    localparam int WIDTH  = 32;
    localparam int CTRL_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_zero;
    logic req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_zero;
    logic [WIDTH-1:0]  req0_a, req0_b, req1_a, req1_b, resp0_result, resp1_result;
    logic [CTRL_W-1:0] req0_ctrl, req1_ctrl, alu_ctrl;
    logic [WIDTH-1:0]  alu_a, alu_b, alu_result;
    logic              alu_zero;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Reference ALU: AND, OR, ADD, SUB; anything else yields 0
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    alu_share_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctrl(req0_ctrl), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_result(resp0_result), .resp0_zero(resp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctrl(req1_ctrl), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_result(resp1_result), .resp1_zero(resp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_ctrl = 4'b0010; resp0_ready = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0; resp1_ready = 1'b0;
        step(); step();
        vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready0: got %0b want 0", req0_ready); end
        vectors++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin miscompares++; $display("FAIL rst_resp_valid: got %0b%0b want 00", resp0_valid, resp1_valid); end
        vectors++; if (resp0_result !== 32'd0 || resp0_zero !== 1'b0) begin miscompares++; $display("FAIL rst_result: got %h/%0b want 0/0", resp0_result, resp0_zero); end
        vectors++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 4'd0) begin miscompares++; $display("FAIL rst_alu_ops: got %h %h %h want 0", alu_a, alu_b, alu_ctrl); end
        req0_valid = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_add;
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 4'b0010;
        #1;
        vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL add_ready: got %0b%0b want 10", req0_ready, req1_ready); end
        step();
        req0_valid = 1'b0;
        vectors++; if (resp0_valid !== 1'b0 || req0_ready !== 1'b0) begin miscompares++; $display("FAIL add_exec: got v=%0b r=%0b want 0 0", resp0_valid, req0_ready); end
        step();
        vectors++; if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0) begin miscompares++; $display("FAIL add_resp_valid: got %0b%0b want 10", resp0_valid, resp1_valid); end
        vectors++; if (resp0_result !== 32'd8 || resp0_zero !== 1'b0) begin miscompares++; $display("FAIL add_result: got %h/%0b want 8/0", resp0_result, resp0_zero); end
        resp0_ready = 1'b1;
        step();
        resp0_ready = 1'b0;
        vectors++; if (resp0_valid !== 1'b0) begin miscompares++; $display("FAIL add_resp_done: got %0b want 0", resp0_valid); end
    endtask

    task automatic test_tie;
        rst_n = 1'b0; step(); rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_ctrl = 4'b0010;
        req1_valid = 1'b1; req1_a = 32'd50; req1_b = 32'd8;  req1_ctrl = 4'b0110;
        #1;
        vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL tie1_grant: got %0b%0b want 10", req0_ready, req1_ready); end
        step();
        req0_valid = 1'b0;
        step();
        vectors++; if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || resp0_result !== 32'd30) begin miscompares++; $display("FAIL tie1_resp: got v=%0b%0b res=%h want 10 1e", resp0_valid, resp1_valid, resp0_result); end
        resp0_ready = 1'b1;
        step();
        resp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = 4'b0010;
        #1;
        vectors++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin miscompares++; $display("FAIL tie2_grant: got %0b%0b want 01", req0_ready, req1_ready); end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        vectors++; if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0 || resp1_result !== 32'd42 || resp1_zero !== 1'b0) begin miscompares++; $display("FAIL tie2_resp: got v=%0b%0b res=%h z=%0b want 01 2a 0", resp0_valid, resp1_valid, resp1_result, resp1_zero); end
        resp1_ready = 1'b1;
        step();
        resp1_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd7; req1_ctrl = 4'b0110;
        #1;
        vectors++; if (req1_ready !== 1'b1) begin miscompares++; $display("FAIL bp_grant1: got %0b want 1", req1_ready); end
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_ctrl = 4'b0010;
        #1;
        vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL bp_exec_ready0: got %0b want 0", req0_ready); end
        step();
        for (int i = 0; i < 3; i++) begin
            vectors++; if (resp1_valid !== 1'b1 || resp1_result !== 32'd0 || resp1_zero !== 1'b1 || req0_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hold%0d: got v=%0b res=%h z=%0b rdy0=%0b want 1 0 1 0", i, resp1_valid, resp1_result, resp1_zero, req0_ready); end
            step();
        end
        resp1_ready = 1'b1;
        #1;
        vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL bp_no_same_cycle_accept: got %0b want 0", req0_ready); end
        step();
        resp1_ready = 1'b0;
        vectors++; if (req0_ready !== 1'b1 || resp1_valid !== 1'b0) begin miscompares++; $display("FAIL bp_next_accept: got rdy0=%0b v1=%0b want 1 0", req0_ready, resp1_valid); end
        step();
        req0_valid = 1'b0;
        step();
        vectors++; if (resp0_valid !== 1'b1 || resp0_result !== 32'd4) begin miscompares++; $display("FAIL bp_req0_result: got v=%0b res=%h want 1 4", resp0_valid, resp0_result); end
        resp0_ready = 1'b1;
        step();
        resp0_ready = 1'b0;
    endtask

    task automatic test_ops;
        logic [31:0] ta [5] = '{32'h0000000F, 32'h0000F0F0, 32'hFFFFFFFF, 32'hF0000000, 32'h00000000};
        logic [31:0] tb [5] = '{32'h0000000F, 32'h00000FF0, 32'h00000001, 32'h0000000F, 32'h00000001};
        logic [3:0]  tc [5] = '{4'b0011, 4'b0000, 4'b0010, 4'b0001, 4'b0110};
        logic [31:0] te [5] = '{32'h00000000, 32'h000000F0, 32'h00000000, 32'hF000000F, 32'hFFFFFFFF};
        logic        tz [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            req0_valid = 1'b1; req0_a = ta[i]; req0_b = tb[i]; req0_ctrl = tc[i];
            step();
            req0_valid = 1'b0;
            vectors++; if (alu_a !== ta[i] || alu_b !== tb[i] || alu_ctrl !== tc[i]) begin miscompares++; $display("FAIL op%0d_alu_drive: got %h %h %h want %h %h %h", i, alu_a, alu_b, alu_ctrl, ta[i], tb[i], tc[i]); end
            step();
            vectors++; if (resp0_valid !== 1'b1 || resp0_result !== te[i] || resp0_zero !== tz[i]) begin miscompares++; $display("FAIL op%0d_result: got v=%0b res=%h z=%0b want 1 %h %0b", i, resp0_valid, resp0_result, resp0_zero, te[i], tz[i]); end
            resp0_ready = 1'b1;
            step();
            resp0_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid_exec;
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_ctrl = 4'b0010;
        #1;
        vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_accept: got %0b want 1", req0_ready); end
        step();
        req0_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || resp0_result !== 32'd0 || resp0_zero !== 1'b0 || alu_a !== 32'd0) begin miscompares++; $display("FAIL rmid_quiet%0d: got v=%0b%0b res=%h z=%0b a=%h want 00 0 0 0", i, resp0_valid, resp1_valid, resp0_result, resp0_zero, alu_a); end
            step();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL rmid_tie: got %0b%0b want 10", req0_ready, req1_ready); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        vectors++; if (req0_ready !== 1'b0 || resp0_valid !== 1'b0 || alu_a !== 32'd0) begin miscompares++; $display("FAIL rmid_withdraw: got rdy0=%0b v0=%0b a=%h want 0 0 0", req0_ready, resp0_valid, alu_a); end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_tie();
        test_backpressure();
        test_ops();
        test_reset_mid_exec();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
